// File: rtl/mem_line_arbiter_pkg.sv
// Shared types for the memory line arbiter: FSM states, pick result and line geometry.
package rv32i_types;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE_I,
        DONE_D
    } arb_state_t;

    typedef enum logic [1:0] {
        PICK_NONE,
        PICK_I,
        PICK_D
    } arb_pick_t;

    localparam int unsigned LINE_BYTES    = 32;
    localparam int unsigned LINE_OFFSET_W = 5;

endpackage

// File: rtl/mem_line_arbiter_if.sv
// Bundles the instruction-side, data-side and physical-memory line ports of the arbiter.
interface mem_line_arbiter_if #(
    parameter int unsigned LINE_W = 256
);
    logic              i_read;
    logic [31:0]       i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [31:0]       d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // slave: the arbiter itself
    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    // master: caches plus physical memory surrounding the arbiter
    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

endinterface

// File: rtl/mem_line_arbiter_priority_pick.sv
// Combinational winner select: data side first, instruction side once starve_cnt saturates.
module arb_priority_pick
    import rv32i_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             req_d,
    input  logic             i_read,
    input  logic [CNT_W-1:0] starve_cnt,
    output arb_pick_t        pick,
    output logic [CNT_W-1:0] starve_next
);

    always_comb begin
        pick        = PICK_NONE;
        starve_next = starve_cnt;
        if (req_d && i_read) begin
            if (starve_cnt < CNT_W'(STARVE_LIMIT)) begin
                pick        = PICK_D;
                starve_next = starve_cnt + CNT_W'(1);
            end else begin
                pick        = PICK_I;
                starve_next = '0;
            end
        end else if (req_d) begin
            pick        = PICK_D;
            starve_next = '0;
        end else if (i_read) begin
            pick        = PICK_I;
            starve_next = '0;
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache miss paths.
module mem_line_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned LINE_W       = 256,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_line_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state, state_n;
    logic [CNT_W-1:0]  starve_cnt, starve_n, starve_pick;
    arb_pick_t         pick;
    logic              rd_q, rd_n, wr_q, wr_n;
    logic [31:0]       addr_q, addr_n;
    logic [LINE_W-1:0] wdata_q, wdata_n;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_n, d_rdata_q, d_rdata_n;
    logic              i_resp_q, i_resp_n, d_resp_q, d_resp_n;
    logic              unused_offset_bits;

    assign unused_offset_bits = ^{bus.i_addr[LINE_OFFSET_W-1:0], bus.d_addr[LINE_OFFSET_W-1:0]};

    arb_priority_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .req_d       (bus.d_read | bus.d_write),
        .i_read      (bus.i_read),
        .starve_cnt  (starve_cnt),
        .pick        (pick),
        .starve_next (starve_pick)
    );

    always_comb begin
        state_n   = state;
        starve_n  = starve_cnt;
        rd_n      = rd_q;
        wr_n      = wr_q;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        i_rdata_n = i_rdata_q;
        d_rdata_n = d_rdata_q;
        i_resp_n  = 1'b0;
        d_resp_n  = 1'b0;
        case (state)
            IDLE: begin
                starve_n = starve_pick;
                case (pick)
                    PICK_D: begin
                        state_n = SERVE_D;
                        addr_n  = {bus.d_addr[31:LINE_OFFSET_W], LINE_OFFSET_W'(0)};
                        // read+write together is illegal; it resolves as a writeback
                        if (bus.d_write) begin
                            wr_n    = 1'b1;
                            wdata_n = bus.d_wdata;
                        end else begin
                            rd_n = 1'b1;
                        end
                    end
                    PICK_I: begin
                        state_n = SERVE_I;
                        addr_n  = {bus.i_addr[31:LINE_OFFSET_W], LINE_OFFSET_W'(0)};
                        rd_n    = 1'b1;
                    end
                    default: ;
                endcase
            end
            SERVE_I: begin
                if (bus.pmem_resp) begin
                    state_n   = DONE_I;
                    rd_n      = 1'b0;
                    i_rdata_n = bus.pmem_rdata;
                    i_resp_n  = 1'b1;
                end
            end
            SERVE_D: begin
                if (bus.pmem_resp) begin
                    state_n = DONE_D;
                    if (rd_q) begin
                        d_rdata_n = bus.pmem_rdata;
                    end
                    rd_n     = 1'b0;
                    wr_n     = 1'b0;
                    d_resp_n = 1'b1;
                end
            end
            DONE_I, DONE_D: state_n = IDLE;
            default:        state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_resp_q   <= 1'b0;
            d_resp_q   <= 1'b0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            rd_q       <= rd_n;
            wr_q       <= wr_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            i_rdata_q  <= i_rdata_n;
            d_rdata_q  <= d_rdata_n;
            i_resp_q   <= i_resp_n;
            d_resp_q   <= d_resp_n;
        end
    end

    assign bus.pmem_read  = rd_q;
    assign bus.pmem_write = wr_q;
    assign bus.pmem_addr  = addr_q;
    assign bus.pmem_wdata = wdata_q;
    assign bus.i_rdata    = i_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.i_resp     = i_resp_q;
    assign bus.d_resp     = d_resp_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Self-checking bench for mem_line_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_mem_line_arbiter;
    import rv32i_types::*;

    localparam int unsigned LINE_W       = 256;
    localparam int unsigned STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [LINE_W-1:0] exp_i_rdata = '0;
    logic [LINE_W-1:0] exp_d_rdata = '0;

    always #5 clk = ~clk;

    mem_line_arbiter_if #(.LINE_W(LINE_W)) bus ();

    mem_line_arbiter #(
        .LINE_W       (LINE_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (bus.pmem_read && bus.pmem_write) begin
                errors++;
                $display("FAIL cmd_exclusive got read=%b write=%b", bus.pmem_read, bus.pmem_write);
            end
            checks++;
            if (bus.i_resp && bus.d_resp) begin
                errors++;
                $display("FAIL resp_exclusive got i_resp=%b d_resp=%b", bus.i_resp, bus.d_resp);
            end
            assert (!(bus.d_read && bus.d_write))
                else $error("illegal request: d_read and d_write both high");
        end
    end

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.i_read     = 1'b0;
        bus.i_addr     = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        repeat (2) tick();
        checks++;
        if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0000", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp});
        end
        checks++;
        if (bus.pmem_addr !== 32'h0 || bus.pmem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_addr_wdata got addr %h wdata %h exp 0", bus.pmem_addr, bus.pmem_wdata);
        end
        checks++;
        if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata got i %h d %h exp 0", bus.i_rdata, bus.d_rdata);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_spurious();
        bus.pmem_rdata = rand_line();
        bus.pmem_resp  = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp} !== 4'b0000 ||
                bus.i_rdata !== '0 || bus.d_rdata !== '0 || bus.pmem_addr !== 32'h0) begin
                errors++;
                $display("FAIL spurious_resp cycle %0d got ctrl %b addr %h exp all zero", c,
                         {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, bus.pmem_addr);
            end
            tick();
        end
    endtask

    task automatic test_i_read();
        logic [31:0]       a;
        logic [LINE_W-1:0] data;
        int unsigned       lat;
        for (int n = 0; n < 4; n++) begin
            a    = (n == 0) ? 32'h0000_1044 : $urandom;
            data = (n == 0) ? {(LINE_W/8){8'hAA}} : rand_line();
            lat  = (n == 0) ? 0 : $urandom_range(0, 5);
            bus.i_read = 1'b1;
            bus.i_addr = a;
            tick();
            checks++;
            if ({bus.pmem_read, bus.pmem_write} !== 2'b10 || bus.pmem_addr !== {a[31:5], 5'b0}) begin
                errors++;
                $display("FAIL i_grant got rw %b addr %h exp rw 10 addr %h",
                         {bus.pmem_read, bus.pmem_write}, bus.pmem_addr, {a[31:5], 5'b0});
            end
            repeat (lat) tick();
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = data;
            tick();
            bus.pmem_resp = 1'b0;
            exp_i_rdata   = data;
            checks++;
            if ({bus.i_resp, bus.d_resp, bus.pmem_read} !== 3'b100 || bus.i_rdata !== exp_i_rdata) begin
                errors++;
                $display("FAIL i_complete got resp/rd %b rdata %h exp 100 rdata %h",
                         {bus.i_resp, bus.d_resp, bus.pmem_read}, bus.i_rdata, exp_i_rdata);
            end
            tick();
            bus.i_read = 1'b0;
            checks++;
            if (bus.i_resp !== 1'b0) begin
                errors++;
                $display("FAIL i_resp_pulse got %b exp 0", bus.i_resp);
            end
            tick();
        end
    endtask

    task automatic test_d_write();
        logic [31:0]       a;
        logic [LINE_W-1:0] w;
        int unsigned       lat;
        for (int n = 0; n < 3; n++) begin
            a   = (n == 0) ? 32'h8000_0020 : $urandom;
            w   = (n == 0) ? {(LINE_W/64){64'h0123_4567_89AB_CDEF}} : rand_line();
            lat = (n == 0) ? 7 : $urandom_range(1, 5);
            bus.d_write = 1'b1;
            bus.d_addr  = a;
            bus.d_wdata = w;
            tick();
            bus.d_wdata = rand_line();
            bus.d_addr  = $urandom;
            for (int c = 0; c <= int'(lat); c++) begin
                checks++;
                if ({bus.pmem_read, bus.pmem_write} !== 2'b01 || bus.pmem_wdata !== w ||
                    bus.pmem_addr !== {a[31:5], 5'b0}) begin
                    errors++;
                    $display("FAIL d_write_hold cycle %0d got rw %b addr %h wdata %h exp rw 01 addr %h wdata %h",
                             c, {bus.pmem_read, bus.pmem_write}, bus.pmem_addr, bus.pmem_wdata, {a[31:5], 5'b0}, w);
                end
                if (c < int'(lat)) tick();
            end
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = rand_line();
            tick();
            bus.pmem_resp = 1'b0;
            checks++;
            if ({bus.d_resp, bus.i_resp, bus.pmem_write, bus.pmem_read} !== 4'b1000 || bus.d_rdata !== exp_d_rdata) begin
                errors++;
                $display("FAIL d_write_done got resp/cmd %b d_rdata %h exp 1000 d_rdata %h",
                         {bus.d_resp, bus.i_resp, bus.pmem_write, bus.pmem_read}, bus.d_rdata, exp_d_rdata);
            end
            tick();
            bus.d_write = 1'b0;
            checks++;
            if (bus.d_resp !== 1'b0) begin
                errors++;
                $display("FAIL d_resp_pulse got %b exp 0", bus.d_resp);
            end
            tick();
        end
    endtask

    task automatic test_starvation();
        logic [31:0]       ia, da;
        logic [LINE_W-1:0] data;
        logic              got_i, exp_i;
        ia = 32'h0000_4000;
        da = 32'h0000_8000;
        bus.i_read = 1'b1;
        bus.i_addr = ia;
        bus.d_read = 1'b1;
        bus.d_addr = da;
        for (int g = 0; g < 2 * (STARVE_LIMIT + 1); g++) begin
            for (int c = 0; c < 4 && !(bus.pmem_read || bus.pmem_write); c++) tick();
            checks++;
            if (!bus.pmem_read) begin
                errors++;
                $display("FAIL starve_timeout grant %0d got no pmem_read", g);
            end
            exp_i = ((g % (STARVE_LIMIT + 1)) == STARVE_LIMIT);
            got_i = (bus.pmem_addr == ia);
            checks++;
            if (got_i !== exp_i) begin
                errors++;
                $display("FAIL starve_order grant %0d got %s exp %s", g, got_i ? "I" : "D", exp_i ? "I" : "D");
            end
            repeat ($urandom_range(0, 3)) tick();
            data = rand_line();
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = data;
            tick();
            bus.pmem_resp = 1'b0;
            if (exp_i) exp_i_rdata = data;
            else       exp_d_rdata = data;
            checks++;
            if ({bus.i_resp, bus.d_resp} !== {exp_i, ~exp_i} || bus.i_rdata !== exp_i_rdata || bus.d_rdata !== exp_d_rdata) begin
                errors++;
                $display("FAIL starve_resp grant %0d got resp %b exp %b", g, {bus.i_resp, bus.d_resp}, {exp_i, ~exp_i});
            end
            if (exp_i) begin
                checks++;
                if (dut.starve_cnt !== '0) begin
                    errors++;
                    $display("FAIL starve_clear grant %0d got %0d exp 0", g, dut.starve_cnt);
                end
            end
            tick();
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        tick();
    endtask

    task automatic test_drop_mid();
        logic [31:0]       a;
        logic [LINE_W-1:0] data;
        a = $urandom;
        bus.d_read = 1'b1;
        bus.d_addr = a;
        tick();
        tick();
        tick();
        bus.d_read = 1'b0;
        bus.d_addr = ~a;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({bus.pmem_read, bus.pmem_write} !== 2'b10 || bus.pmem_addr !== {a[31:5], 5'b0}) begin
                errors++;
                $display("FAIL drop_hold cycle %0d got rw %b addr %h exp rw 10 addr %h",
                         c, {bus.pmem_read, bus.pmem_write}, bus.pmem_addr, {a[31:5], 5'b0});
            end
            tick();
        end
        data = rand_line();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = data;
        tick();
        bus.pmem_resp = 1'b0;
        exp_d_rdata   = data;
        checks++;
        if (bus.d_resp !== 1'b1 || bus.d_rdata !== exp_d_rdata) begin
            errors++;
            $display("FAIL drop_complete got d_resp %b d_rdata %h exp 1 %h", bus.d_resp, bus.d_rdata, exp_d_rdata);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({bus.d_resp, bus.pmem_read, bus.pmem_write} !== 3'b000) begin
                errors++;
                $display("FAIL drop_after cycle %0d got %b exp 000", c, {bus.d_resp, bus.pmem_read, bus.pmem_write});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0]       a;
        logic [LINE_W-1:0] data;
        a = $urandom;
        bus.i_read = 1'b1;
        bus.i_addr = a;
        repeat (4) tick();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got pmem_read %b exp 0", bus.pmem_read);
        end
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        repeat (2) tick();
        checks++;
        if (bus.i_resp !== 1'b0 || bus.i_rdata !== '0) begin
            errors++;
            $display("FAIL reset_noresp got i_resp %b i_rdata %h exp 0", bus.i_resp, bus.i_rdata);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_addr !== {a[31:5], 5'b0}) begin
            errors++;
            $display("FAIL reset_regrant got rd %b addr %h exp 1 %h", bus.pmem_read, bus.pmem_addr, {a[31:5], 5'b0});
        end
        tick();
        data = rand_line();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = data;
        tick();
        bus.pmem_resp = 1'b0;
        exp_i_rdata   = data;
        checks++;
        if (bus.i_resp !== 1'b1 || bus.i_rdata !== exp_i_rdata) begin
            errors++;
            $display("FAIL reset_complete got i_resp %b i_rdata %h exp 1 %h", bus.i_resp, bus.i_rdata, exp_i_rdata);
        end
        tick();
        bus.i_read = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic              i_pend = 1'b0;
        logic              d_pend = 1'b0;
        int unsigned       waited_d = 0;
        logic [31:0]       ia = '0;
        logic [31:0]       da = '0;
        logic              dw = 1'b0;
        logic [LINE_W-1:0] dwd = '0;
        logic [LINE_W-1:0] rd;
        logic              win_d;
        logic [1:0]        exp_cmd;
        logic [31:0]       exp_addr;
        for (int r = 0; r < 40; r++) begin
            if (!i_pend && $urandom_range(0, 2) != 0) begin
                i_pend     = 1'b1;
                ia         = $urandom;
                bus.i_read = 1'b1;
                bus.i_addr = ia;
            end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend      = 1'b1;
                da          = $urandom;
                dw          = 1'($urandom_range(0, 1));
                dwd         = rand_line();
                bus.d_read  = ~dw;
                bus.d_write = dw;
                bus.d_addr  = da;
                bus.d_wdata = dwd;
            end
            if (!i_pend && !d_pend) begin
                tick();
                continue;
            end
            // data wins unless the instruction side has already been passed over STARVE_LIMIT times
            if (i_pend && d_pend) begin
                win_d = (waited_d < STARVE_LIMIT);
                waited_d = win_d ? waited_d + 1 : 0;
            end else begin
                win_d    = d_pend;
                waited_d = 0;
            end
            exp_cmd  = (win_d && dw) ? 2'b01 : 2'b10;
            exp_addr = win_d ? {da[31:5], 5'b0} : {ia[31:5], 5'b0};
            tick();
            for (int c = 0; c <= 3; c++) begin
                checks++;
                if ({bus.pmem_read, bus.pmem_write} !== exp_cmd || bus.pmem_addr !== exp_addr ||
                    (win_d && dw && bus.pmem_wdata !== dwd)) begin
                    errors++;
                    $display("FAIL rand_cmd round %0d got rw %b addr %h exp rw %b addr %h",
                             r, {bus.pmem_read, bus.pmem_write}, bus.pmem_addr, exp_cmd, exp_addr);
                end
                if (c == 3 || $urandom_range(0, 1) == 0) break;
                tick();
            end
            rd = rand_line();
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = rd;
            tick();
            bus.pmem_resp = 1'b0;
            if (!win_d)   exp_i_rdata = rd;
            else if (!dw) exp_d_rdata = rd;
            checks++;
            if ({bus.i_resp, bus.d_resp} !== {~win_d, win_d} || bus.i_rdata !== exp_i_rdata ||
                bus.d_rdata !== exp_d_rdata || {bus.pmem_read, bus.pmem_write} !== 2'b00) begin
                errors++;
                $display("FAIL rand_done round %0d got resp %b exp %b (rdata i %s d %s)", r,
                         {bus.i_resp, bus.d_resp}, {~win_d, win_d},
                         (bus.i_rdata === exp_i_rdata) ? "ok" : "bad", (bus.d_rdata === exp_d_rdata) ? "ok" : "bad");
            end
            tick();
            if (win_d) begin
                d_pend      = 1'b0;
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
            end else begin
                i_pend     = 1'b0;
                bus.i_read = 1'b0;
            end
        end
        bus.i_read  = 1'b0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_spurious();
        test_i_read();
        test_d_write();
        test_starvation();
        test_drop_mid();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
